// File: rtl/leading_one_scan.sv
// leading_one_scan
// Multi-cycle bit-position finder. A captured word is scanned one CHUNK-bit slice per
// cycle, starting at the top slice (leading mode) or the bottom slice (trailing mode),
// and the scan stops at the first non-zero slice.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   request valid
//   in_ready   block idle and able to accept a request
//   in_data    word to scan (sampled only on accept)
//   in_dir     0 = leading (highest set bit), 1 = trailing (lowest set bit)
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   out_pos    bit index of the found one
//   out_zero   word was all zeros (out_pos is 0 in that case)
module leading_one_scan #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned CHUNK      = 8,
   parameter int unsigned NCHUNK     = WIDTH / CHUNK,
   parameter int unsigned LOG2_WIDTH = $clog2(WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   input  logic                  in_dir,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [LOG2_WIDTH-1:0] out_pos,
   output logic                  out_zero
);

   // Slice index needs at least one bit even when there is a single slice.
   localparam int unsigned IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_t;

   state_t          state_q;
   logic [WIDTH-1:0] word_q;
   logic            dir_q;
   logic [IDXW-1:0] idx_q;

   logic [CHUNK-1:0]      slice;
   logic [LOG2_WIDTH-1:0] lead_local;
   logic [LOG2_WIDTH-1:0] trail_local;
   logic [LOG2_WIDTH-1:0] local_idx;
   logic [LOG2_WIDTH-1:0] slice_pos;
   logic                  slice_nz;
   logic                  last_slice;
   logic [IDXW-1:0]       next_idx;

   assign in_ready = (state_q == StIdle);

   // Current slice select, written as a mux over constant offsets.
   always_comb begin
      slice = '0;
      for (int unsigned c = 0; c < NCHUNK; c++) begin
         if (idx_q == IDXW'(c)) begin
            slice = word_q[c*CHUNK +: CHUNK];
         end
      end
   end

   // Highest set bit wins in the upward loop, lowest set bit wins in the downward loop.
   always_comb begin
      lead_local  = '0;
      trail_local = '0;
      for (int unsigned i = 0; i < CHUNK; i++) begin
         if (slice[i]) begin
            lead_local = LOG2_WIDTH'(i);
         end
      end
      for (int i = int'(CHUNK) - 1; i >= 0; i--) begin
         if (slice[i]) begin
            trail_local = LOG2_WIDTH'(i);
         end
      end
   end

   always_comb begin
      local_idx  = dir_q ? trail_local : lead_local;
      // idx*CHUNK never exceeds WIDTH-CHUNK, so the sum always fits in LOG2_WIDTH bits.
      slice_pos  = LOG2_WIDTH'(idx_q) * LOG2_WIDTH'(CHUNK) + local_idx;
      slice_nz   = |slice;
      last_slice = dir_q ? (idx_q == LAST_IDX) : (idx_q == '0);
      next_idx   = dir_q ? (idx_q + IDXW'(1)) : (idx_q - IDXW'(1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         word_q    <= '0;
         dir_q     <= 1'b0;
         idx_q     <= '0;
         out_valid <= 1'b0;
         out_pos   <= '0;
         out_zero  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  word_q  <= in_data;
                  dir_q   <= in_dir;
                  idx_q   <= in_dir ? '0 : LAST_IDX;
                  state_q <= StScan;
               end
            end
            StScan: begin
               if (slice_nz) begin
                  out_pos   <= slice_pos;
                  out_zero  <= 1'b0;
                  out_valid <= 1'b1;
                  state_q   <= StDone;
               end else if (last_slice) begin
                  out_pos   <= '0;
                  out_zero  <= 1'b1;
                  out_valid <= 1'b1;
                  state_q   <= StDone;
               end else begin
                  idx_q <= next_idx;
               end
            end
            StDone: begin
               // out_pos/out_zero deliberately keep their value after the handshake.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/leading_one_scan.md
Name: leading_one_scan

Overview:
- Multi-cycle, parametrised bit-position finder for wide words; successor to the single-cycle combinational leading-one encoder.
- Scans the captured word one CHUNK-bit slice per cycle and stops at the first non-zero slice.
- Mode selectable per transaction: leading (highest set bit) or trailing (lowest set bit).
- Valid/ready handshakes on both sides; sits between a normaliser/scheduler front end and its consumer.

Parameters:
- WIDTH, 32, input word width; must be a multiple of CHUNK.
- CHUNK, 8, bits examined per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK, WIDTH/CHUNK, derived slice count; not to be overridden.
- LOG2_WIDTH, $clog2(WIDTH), position width; not to be overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_data  in  WIDTH  word to scan.
- in_dir  in  1  0 = leading (highest set bit), 1 = trailing (lowest set bit).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_pos  out  LOG2_WIDTH  bit index of found one.
- out_zero  out  1  word was all zeros.

Behaviour:
- Reset (asynchronous, immediate): state IDLE, out_valid=0, out_pos=0, out_zero=0, captured word, dir and slice index cleared. in_ready=1 once state is IDLE.
- States IDLE, SCAN, DONE. in_ready = (state==IDLE), combinational from state only.
- IDLE: on rising edge with in_valid & in_ready, capture in_data and in_dir, then go to SCAN. Start slice is NCHUNK-1 for leading mode and 0 for trailing mode.
- in_data and in_dir are sampled only at accept; later changes are ignored.
- SCAN: each cycle examine the current slice s = word[s*CHUNK +: CHUNK].
  - If the slice is non-zero: out_pos = s*CHUNK + local index. Local index is the highest set bit for leading mode, the lowest for trailing mode. out_zero=0, go to DONE.
  - If the slice is zero and it is the final slice (0 for leading, NCHUNK-1 for trailing): out_pos=0, out_zero=1, go to DONE.
  - Otherwise, step the slice toward the final slice (decrement for leading, increment for trailing) and stay in SCAN.
- Latency: with k = number of slices examined (1..NCHUNK), out_valid rises at the k-th rising edge after the accepting edge.
  - Leading mode: k = NCHUNK - index of highest non-zero slice.
  - Trailing mode: k = index of lowest non-zero slice + 1.
  - All-zero word: k = NCHUNK.
- DONE: out_valid=1; out_pos and out_zero are held stable while out_ready=0. On an edge with out_ready=1, clear out_valid and go to IDLE. out_pos and out_zero keep their last value, so they are don't-care when out_valid=0.
- One request in flight; no accept outside IDLE. Throughput is one result per k+2 cycles with out_ready held high.
- out_ready asserted while out_valid=0 has no effect. in_valid while in_ready=0 is not accepted and not queued.
- CHUNK==WIDTH: single SCAN cycle, so k=1 always.
- Reset mid-SCAN or mid-DONE: transaction dropped, no result emitted, outputs return to reset values immediately.
- Position arithmetic is unsigned, LOG2_WIDTH bits; max value is WIDTH-1, so it never overflows.

Test Plan:
- WIDTH=32, CHUNK=8, leading mode, in_data=0x8000_0000 -> out_valid 1 cycle after accept, out_pos=31, out_zero=0; out_ready=1 -> IDLE, in_ready=1 next cycle.
- Leading mode, in_data=0x0000_0001 -> 4 slices scanned, out_valid 4 cycles after accept, out_pos=0, out_zero=0. Same word in trailing mode -> out_valid after 1 cycle, out_pos=0.
- in_data=0x0010_0100 -> leading: out_pos=20 after 2 cycles; trailing: out_pos=8 after 2 cycles.
- in_data=0x0000_0000 in either mode -> out_valid after 4 cycles, out_zero=1, out_pos=0.
- Backpressure: result ready, out_ready=0 for 5 cycles while in_valid=1 with new data -> out_pos and out_zero stable, in_ready=0, new data not accepted. Then out_ready=1 -> one IDLE cycle, new request accepted, and its result is correct.
- Assert rst during SCAN of 0x0000_0001 -> out_valid stays 0, no result emitted, in_ready=1 after release. Also repeat the first scenario with CHUNK=32 -> out_pos=31 after 1 cycle.
